// File: rtl/data_pack.sv
// Repacks an LSB-first stream of IN_W-bit values into OUT_W-bit words with sop/eop
// framing, buffered in a small show-ahead FIFO drained through valid/ready.
module data_pack #(
  parameter int IN_W       = 7,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  data_in,
  input  logic             sop_in,
  input  logic             eop_in,
  output logic             valid_out,
  output logic [OUT_W-1:0] data_out,
  output logic             sop_out,
  output logic             eop_out,
  input  logic             ready_in,
  output logic             overflow,
  output logic             pkt_err
);

  localparam int ACC_W = OUT_W + IN_W - 1;
  localparam int CNT_W = $clog2(OUT_W);
  localparam int SUM_W = $clog2(OUT_W + IN_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = OUT_W + 2;

  typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               first_reg, first_next;
  logic               pkt_err_reg, pkt_err_next;

  logic               push, push_sop, push_eop;
  logic [OUT_W-1:0]   push_data;
  logic [OUT_W-1:0]   flush_mask;

  logic               do_pack, restart, first_eff;
  logic [ACC_W-1:0]   base_acc, packed_acc, new_acc;
  logic [CNT_W-1:0]   base_cnt, new_cnt;
  logic [SUM_W-1:0]   sum;

  // Keeps only the cnt valid residual bits of the flushed word.
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_mask
      assign flush_mask[gi] = (CNT_W'(gi) < cnt_reg);
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    first_next   = first_reg;
    pkt_err_next = 1'b0;
    push         = 1'b0;
    push_data    = '0;
    push_sop     = 1'b0;
    push_eop     = 1'b0;
    do_pack      = 1'b0;
    restart      = 1'b0;
    new_acc      = '0;
    new_cnt      = '0;

    case (state_reg)
      IDLE: begin
        if (valid_in && sop_in) begin
          do_pack = 1'b1;
          restart = 1'b1;
        end
      end
      PACK: begin
        if (valid_in) begin
          do_pack      = 1'b1;
          restart      = sop_in;
          pkt_err_next = sop_in;
        end
      end
      FLUSH: begin
        push       = 1'b1;
        push_data  = acc_reg[OUT_W-1:0] & flush_mask;
        push_sop   = first_reg;
        push_eop   = 1'b1;
        acc_next   = '0;
        cnt_next   = '0;
        first_next = 1'b0;
        state_next = IDLE;
        if (valid_in && sop_in) begin
          do_pack = 1'b1;
          restart = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A new packet starts from a cleared accumulator; any partial word is dropped.
    base_acc   = restart ? '0 : acc_reg;
    base_cnt   = restart ? '0 : cnt_reg;
    first_eff  = restart | first_reg;
    packed_acc = base_acc | (ACC_W'(data_in) << base_cnt);
    sum        = SUM_W'(base_cnt) + SUM_W'(IN_W);

    if (do_pack) begin
      first_next = first_eff;
      // A value packed on a FLUSH cycle starts at bit 0, so it never completes a word.
      if (sum >= SUM_W'(OUT_W)) begin
        push       = 1'b1;
        push_data  = packed_acc[OUT_W-1:0];
        push_sop   = first_eff;
        first_next = 1'b0;
        new_acc    = packed_acc >> OUT_W;
        new_cnt    = CNT_W'(sum - SUM_W'(OUT_W));
      end else begin
        new_acc = packed_acc;
        new_cnt = CNT_W'(sum);
      end

      if (eop_in) begin
        if (new_cnt != '0) begin
          state_next = FLUSH;
          acc_next   = new_acc;
          cnt_next   = new_cnt;
        end else begin
          push_eop   = 1'b1;
          acc_next   = '0;
          cnt_next   = '0;
          first_next = 1'b0;
          state_next = IDLE;
        end
      end else begin
        state_next = PACK;
        acc_next   = new_acc;
        cnt_next   = new_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      first_reg   <= 1'b0;
      pkt_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      first_reg   <= first_next;
      pkt_err_reg <= pkt_err_next;
    end
  end

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             overflow_reg;
  logic             pop, full, wr_en;
  logic [ENT_W-1:0] head;

  assign full  = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign pop   = valid_out & ready_in;
  assign wr_en = push & (~full | pop);
  assign head  = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {push_sop, push_eop, push_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_en && !pop)      count_reg <= count_reg + 1'b1;
      else if (!wr_en && pop) count_reg <= count_reg - 1'b1;
      if (push && full && !pop) overflow_reg <= 1'b1;
    end
  end

  // Head fields are gated so an empty FIFO (including under reset) presents zeros.
  assign valid_out = (count_reg != '0);
  assign data_out  = valid_out ? head[OUT_W-1:0] : '0;
  assign eop_out   = valid_out & head[OUT_W];
  assign sop_out   = valid_out & head[OUT_W+1];
  assign overflow  = overflow_reg;
  assign pkt_err   = pkt_err_reg;

endmodule

// File: tb/tb_data_pack.sv
// Directed bench for data_pack: hand-computed words checked through a scoreboard
// that also verifies the cycle each word appears while ready_in is high.
module tb_data_pack;

  localparam int IN_W  = 7;
  localparam int OUT_W = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_in = 1'b0;
  logic [IN_W-1:0]  data_in = '0;
  logic             sop_in = 1'b0;
  logic             eop_in = 1'b0;
  logic             ready_in = 1'b1;
  logic             valid_out;
  logic [OUT_W-1:0] data_out;
  logic             sop_out;
  logic             eop_out;
  logic             overflow;
  logic             pkt_err;

  data_pack #(.IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .sop_in(sop_in), .eop_in(eop_in), .valid_out(valid_out), .data_out(data_out),
    .sop_out(sop_out), .eop_out(eop_out), .ready_in(ready_in),
    .overflow(overflow), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
    int          c;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic s, input logic e, input int c);
    exp_t w;
    w.d = d; w.s = s; w.e = e; w.c = c;
    exp_q.push_back(w);
  endtask

  // One input beat; returns 1 time unit after the accepting edge with inputs idle.
  task automatic beat(input logic v, input logic [IN_W-1:0] d, input logic s, input logic e);
    @(negedge clk);
    valid_in = v; data_in = d; sop_in = s; eop_in = e;
    @(posedge clk);
    #1;
    valid_in = 1'b0; data_in = '0; sop_in = 1'b0; eop_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", valid_out, 1'b0);
      end else begin
        e = exp_q.pop_front();
        $display("word data=%h sop=%0b eop=%0b cyc=%0d", data_out, sop_out, eop_out, cyc);
        check("word_data", data_out, e.d);
        check("word_sop", sop_out, e.s);
        check("word_eop", eop_out, e.e);
        if (e.c >= 0) check("word_cycle", cyc, e.c);
      end
    end
  end

  logic [IN_W-1:0] t1_vals [10] = '{7'h5A, 7'h00, 7'h33, 7'h00, 7'h7F,
                                    7'h00, 7'h00, 7'h00, 7'h7D, 7'h40};
  logic [IN_W-1:0] t6_vals [4]  = '{7'h01, 7'h02, 7'h03, 7'h7F};

  initial begin
    int w;
    #12;
    check("rst_valid", valid_out, 1'b0);
    check("rst_data", data_out, 32'h0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_pkt_err", pkt_err, 1'b0);
    rst_n = 1'b1;

    // Test 1: open packet, two full words
    for (int i = 0; i < 10; i++) begin
      beat(1'b1, t1_vals[i], i == 0, 1'b0);
      if (i == 4) expect_word(32'hF00CC05A, 1'b1, 1'b0, cyc);
      if (i == 9) expect_word(32'h7D000007, 1'b0, 1'b0, cyc);
    end
    idle(3);
    check("t1_done", exp_q.size(), 0);
    do_reset();

    // Test 2: 5-value packet, eop leaves 3 residual bits -> FLUSH word
    beat(1'b1, 7'h01, 1'b1, 1'b0);
    beat(1'b1, 7'h02, 1'b0, 1'b0);
    beat(1'b1, 7'h03, 1'b0, 1'b0);
    beat(1'b1, 7'h04, 1'b0, 1'b0);
    beat(1'b1, 7'h7F, 1'b0, 1'b1);
    expect_word(32'hF080C101, 1'b1, 1'b0, cyc);
    expect_word(32'h00000007, 1'b0, 1'b1, cyc + 1);
    idle(3);
    check("t2_done", exp_q.size(), 0);

    // Test 3: 224 bits -> exactly 7 words, last carries eop, no flush word
    w = 0;
    for (int i = 0; i < 32; i++) begin
      beat(1'b1, 7'h7F, i == 0, i == 31);
      if ((7 * (i + 1)) / 32 != (7 * i) / 32) begin
        expect_word(32'hFFFFFFFF, w == 0, w == 6, cyc);
        w++;
      end
    end
    idle(3);
    check("t3_words", w, 7);
    check("t3_done", exp_q.size(), 0);

    // Test 4: single-value packet A, packet B starts on A's FLUSH cycle
    beat(1'b1, 7'h55, 1'b1, 1'b1);
    expect_word(32'h00000055, 1'b1, 1'b1, cyc + 1);
    beat(1'b1, 7'h11, 1'b1, 1'b0);
    beat(1'b1, 7'h22, 1'b0, 1'b0);
    beat(1'b1, 7'h33, 1'b0, 1'b0);
    beat(1'b1, 7'h44, 1'b0, 1'b0);
    beat(1'b1, 7'h7F, 1'b0, 1'b1);
    expect_word(32'hF88CD111, 1'b1, 1'b0, cyc);
    expect_word(32'h00000007, 1'b0, 1'b1, cyc + 1);
    idle(3);
    check("t4_done", exp_q.size(), 0);

    // Test 5: backpressure, fifth word overflows
    ready_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      beat(1'b1, 7'(k), 1'b1, 1'b1);
      idle(1);
      if (k <= 4) expect_word(32'(k), 1'b1, 1'b1, -1);
      if (k == 4) check("t5_no_overflow_at_full", overflow, 1'b0);
    end
    check("t5_overflow", overflow, 1'b1);
    check("t5_valid_held", valid_out, 1'b1);
    idle(2);
    check("t5_head_held", data_out, 32'h1);
    ready_in = 1'b1;
    idle(6);
    check("t5_drained", exp_q.size(), 0);
    check("t5_empty", valid_out, 1'b0);

    // Test 6: pre-sop values discarded, mid-packet sop -> pkt_err
    repeat (5) beat(1'b1, 7'h7F, 1'b0, 1'b0);
    idle(1);
    check("t6_presop_discard", valid_out, 1'b0);
    beat(1'b1, 7'h0A, 1'b1, 1'b0);
    check("t6_no_err", pkt_err, 1'b0);
    beat(1'b1, 7'h0B, 1'b0, 1'b0);
    beat(1'b1, 7'h0C, 1'b1, 1'b0);
    check("t6_pkt_err", pkt_err, 1'b1);
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, t6_vals[i], 1'b0, i == 3);
      if (i == 0) check("t6_pkt_err_pulse", pkt_err, 1'b0);
    end
    expect_word(32'hF060808C, 1'b1, 1'b0, cyc);
    expect_word(32'h00000007, 1'b0, 1'b1, cyc + 1);
    idle(3);
    check("t6_done", exp_q.size(), 0);

    // Async reset mid-packet with a held word and sticky overflow
    ready_in = 1'b0;
    beat(1'b1, 7'h01, 1'b1, 1'b0);
    beat(1'b1, 7'h02, 1'b0, 1'b0);
    beat(1'b1, 7'h03, 1'b0, 1'b0);
    beat(1'b1, 7'h04, 1'b0, 1'b0);
    beat(1'b1, 7'h7F, 1'b0, 1'b0);
    beat(1'b1, 7'h0C, 1'b1, 1'b0);
    check("ar_valid_before", valid_out, 1'b1);
    check("ar_overflow_before", overflow, 1'b1);
    check("ar_pkt_err_before", pkt_err, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", valid_out, 1'b0);
    check("ar_data", data_out, 32'h0);
    check("ar_sop", sop_out, 1'b0);
    check("ar_eop", eop_out, 1'b0);
    check("ar_overflow", overflow, 1'b0);
    check("ar_pkt_err", pkt_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_in = 1'b1;
    idle(3);
    check("ar_fifo_flushed", valid_out, 1'b0);
    check("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
